// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types for the SoC crossbar and its slaves.
package axi4l_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef logic [1:0]  resp_t;

    localparam resp_t RespOkay   = 2'b00;
    localparam resp_t RespSlverr = 2'b10;

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bundle with master and slave views.
interface axi4l_if (
    input logic aclk,
    input logic aresetn
);

    axi4l_pkg::addr_t awaddr;
    logic             awvalid;
    logic             awready;
    axi4l_pkg::data_t wdata;
    axi4l_pkg::strb_t wstrb;
    logic             wvalid;
    logic             wready;
    axi4l_pkg::resp_t bresp;
    logic             bvalid;
    logic             bready;
    axi4l_pkg::addr_t araddr;
    logic             arvalid;
    logic             arready;
    axi4l_pkg::data_t rdata;
    axi4l_pkg::resp_t rresp;
    logic             rvalid;
    logic             rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi4l_timer.sv
// AXI4-Lite RISC-V machine timer: 64-bit mtime/mtimecmp with a programmable prescaler.
module axi4l_timer
    import axi4l_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = 16'd0
) (
    input  logic   aclk,
    input  logic   aresetn,
    axi4l_if.slave axis,
    output logic   irq_timer_o
);

    localparam logic [2:0] IdxMtimeLo = 3'd0;
    localparam logic [2:0] IdxMtimeHi = 3'd1;
    localparam logic [2:0] IdxCmpLo   = 3'd2;
    localparam logic [2:0] IdxCmpHi   = 3'd3;
    localparam logic [2:0] IdxDiv     = 3'd4;

    logic        aw_held_q, w_held_q, bvalid_q, rvalid_q, irq_q;
    logic [2:0]  aw_idx_q;
    data_t       wdata_q, rdata_q;
    strb_t       wstrb_q;
    resp_t       bresp_q, rresp_q;
    logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic [15:0] div_q, div_d, cnt_q, cnt_d;
    logic [31:0] shadow_q;

    logic        aw_hs, w_hs, ar_hs, write_fire, tick, wr_err, rd_err;
    logic [2:0]  wr_idx, rd_idx;
    data_t       wr_data, rd_data;
    strb_t       wr_strb;
    logic [31:0] div_merge;
    logic        unused_bits;

    function automatic logic [31:0] merge_bytes(logic [31:0] old_v, logic [31:0] new_v,
                                                logic [3:0] strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    assign axis.awready = !aw_held_q && !bvalid_q;
    assign axis.wready  = !w_held_q && !bvalid_q;
    assign axis.arready = !rvalid_q;
    assign axis.bvalid  = bvalid_q;
    assign axis.bresp   = bresp_q;
    assign axis.rvalid  = rvalid_q;
    assign axis.rdata   = rdata_q;
    assign axis.rresp   = rresp_q;
    assign irq_timer_o  = irq_q;

    assign aw_hs = axis.awvalid && axis.awready;
    assign w_hs  = axis.wvalid && axis.wready;
    assign ar_hs = axis.arvalid && axis.arready;

    // Commit once both halves sit in holding registers, or immediately if they arrive together.
    assign write_fire = (aw_held_q && w_held_q) || (aw_hs && w_hs);
    assign wr_idx     = aw_held_q ? aw_idx_q : axis.awaddr[4:2];
    assign wr_data    = w_held_q ? wdata_q : axis.wdata;
    assign wr_strb    = w_held_q ? wstrb_q : axis.wstrb;
    assign rd_idx     = axis.araddr[4:2];
    assign tick       = (cnt_q == div_q);
    assign div_merge  = merge_bytes({16'h0, div_q}, wr_data, wr_strb);

    assign unused_bits = ^{axis.awaddr[31:5], axis.awaddr[1:0], axis.araddr[31:5],
                           axis.araddr[1:0], div_merge[31:16]};

    // Next-state of the timer registers: tick first, then overlay any written bytes.
    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        div_d      = div_q;
        cnt_d      = tick ? 16'd0 : cnt_q + 16'd1;
        wr_err     = 1'b0;
        if (write_fire) begin
            case (wr_idx)
                IdxMtimeLo: mtime_d[31:0]     = merge_bytes(mtime_d[31:0], wr_data, wr_strb);
                IdxMtimeHi: mtime_d[63:32]    = merge_bytes(mtime_d[63:32], wr_data, wr_strb);
                IdxCmpLo:   mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wr_data, wr_strb);
                IdxCmpHi:   mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wr_data, wr_strb);
                IdxDiv: begin
                    // An all-zero strobe is a no-op, so it must not disturb the prescale phase.
                    if (|wr_strb) begin
                        div_d = div_merge[15:0];
                        cnt_d = 16'd0;
                    end
                end
                default: wr_err = 1'b1;
            endcase
        end
    end

    // Read-data decode for the address presented on AR.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (rd_idx)
            IdxMtimeLo: rd_data = mtime_q[31:0];
            IdxMtimeHi: rd_data = shadow_q;
            IdxCmpLo:   rd_data = mtimecmp_q[31:0];
            IdxCmpHi:   rd_data = mtimecmp_q[63:32];
            IdxDiv:     rd_data = {16'h0, div_q};
            default:    rd_err  = 1'b1;
        endcase
    end

    // Timer state and the registered interrupt compare.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            div_q      <= DIV_RESET;
            cnt_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    // Write channel: independent AW/W capture, single outstanding response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
        end else begin
            if (bvalid_q && axis.bready) bvalid_q <= 1'b0;
            if (write_fire) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_err ? RespSlverr : RespOkay;
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    aw_idx_q  <= axis.awaddr[4:2];
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    wdata_q  <= axis.wdata;
                    wstrb_q  <= axis.wstrb;
                end
            end
        end
    end

    // Read channel: registered response; an MTIME_LO read freezes the upper word for MTIME_HI.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RespOkay;
            shadow_q <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_err ? RespSlverr : RespOkay;
            if (rd_idx == IdxMtimeLo) shadow_q <= mtime_q[63:32];
        end else if (rvalid_q && axis.rready) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4l_timer.sv
// Randomised scoreboard bench for the AXI4-Lite machine timer.
module tb_axi4l_timer;
    import axi4l_pkg::*;

    localparam logic [15:0] DivReset = 16'd0;

    typedef struct {
        data_t data;
        resp_t resp;
    } rd_exp_t;

    logic aclk;
    logic aresetn;
    logic irq;

    axi4l_if axis_if (.aclk(aclk), .aresetn(aresetn));

    axi4l_timer #(.DIV_RESET(DivReset)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .axis       (axis_if),
        .irq_timer_o(irq)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Edge counter: edge 1 is the first rising edge after reset release.
    int unsigned cyc;
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    int errors = 0;
    int checks = 0;

    resp_t   b_q[$];
    rd_exp_t r_q[$];

    // Reference model: mtime after edge n = base + whole prescale periods elapsed since base_edge,
    // periods counted from the last prescaler restart (reset or DIV write).
    logic [63:0] m_base;
    int unsigned m_base_edge;
    int unsigned m_phase;
    logic [15:0] m_div;
    logic [63:0] m_cmp;
    logic [31:0] m_shadow;
    int unsigned last_upd;

    function automatic logic [63:0] ticks(int unsigned n);
        return (64'(n) - 64'(m_phase)) / (64'(m_div) + 64'd1);
    endfunction

    function automatic logic [63:0] mval(int unsigned n);
        if (n < m_base_edge) return m_base;
        return m_base + (ticks(n) - ticks(m_base_edge));
    endfunction

    function automatic logic [31:0] lane_merge(logic [31:0] old_v, logic [31:0] new_v,
                                               logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_base      = '0;
        m_base_edge = 0;
        m_phase     = 0;
        m_div       = DivReset;
        m_cmp       = '1;
        m_shadow    = '0;
        last_upd    = 0;
    endtask

    task automatic model_write(logic [2:0] idx, data_t d, strb_t s, int unsigned u);
        logic [63:0] cur;
        logic [31:0] w;
        cur = mval(u);
        case (idx)
            3'd0: begin m_base = {cur[63:32], lane_merge(cur[31:0], d, s)}; m_base_edge = u; end
            3'd1: begin m_base = {lane_merge(cur[63:32], d, s), cur[31:0]}; m_base_edge = u; end
            3'd2: m_cmp[31:0]  = lane_merge(m_cmp[31:0], d, s);
            3'd3: m_cmp[63:32] = lane_merge(m_cmp[63:32], d, s);
            3'd4: if (s != 4'h0) begin
                w           = lane_merge({16'h0, m_div}, d, s);
                m_base      = cur;
                m_base_edge = u;
                m_phase     = u;
                m_div       = w[15:0];
            end
            default: ;
        endcase
        last_upd = u;
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within its cycle budget (edge %0d)", name, cyc);
    endtask

    // Monitor: pops the scoreboard whenever a response handshakes, and checks the interrupt.
    initial begin
        resp_t   be;
        rd_exp_t re;
        forever begin
            @(negedge aclk);
            #2;
            if (aresetn === 1'b1) begin
                if (axis_if.bvalid && axis_if.bready) begin
                    if (b_q.size() == 0) fail_now("bresp_unexpected");
                    else begin
                        be = b_q.pop_front();
                        check("bresp", 64'(axis_if.bresp), 64'(be));
                    end
                end
                if (axis_if.rvalid && axis_if.rready) begin
                    if (r_q.size() == 0) fail_now("rresp_unexpected");
                    else begin
                        re = r_q.pop_front();
                        check("rdata", 64'(axis_if.rdata), 64'(re.data));
                        check("rresp", 64'(axis_if.rresp), 64'(re.resp));
                    end
                end
                if (cyc >= 2 && cyc >= last_upd + 2)
                    check("irq", 64'(irq), 64'(mval(cyc - 1) >= m_cmp));
            end
        end
    end

    task automatic aw_send(addr_t a, output int unsigned e, output bit ok);
        ok = 1'b0;
        e  = 0;
        axis_if.awaddr  = a;
        axis_if.awvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (axis_if.awready) begin
                e  = cyc + 1;
                ok = 1'b1;
                @(negedge aclk);
                break;
            end
            @(negedge aclk);
        end
        axis_if.awvalid = 1'b0;
    endtask

    task automatic w_send(data_t d, strb_t s, output int unsigned e, output bit ok);
        ok = 1'b0;
        e  = 0;
        axis_if.wdata  = d;
        axis_if.wstrb  = s;
        axis_if.wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (axis_if.wready) begin
                e  = cyc + 1;
                ok = 1'b1;
                @(negedge aclk);
                break;
            end
            @(negedge aclk);
        end
        axis_if.wvalid = 1'b0;
    endtask

    // Waits for bvalid, stalls bready for 'delay' cycles checking the channel stays frozen.
    task automatic finish_b(int delay);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (axis_if.bvalid) begin seen = 1'b1; break; end
            @(negedge aclk);
        end
        if (!seen) begin fail_now("bvalid_wait"); return; end
        for (int i = 0; i < delay; i++) begin
            check("bvalid_hold", 64'(axis_if.bvalid), 64'd1);
            check("awready_stall", 64'(axis_if.awready), 64'd0);
            @(negedge aclk);
        end
        axis_if.bready = 1'b1;
        @(negedge aclk);
        axis_if.bready = 1'b0;
    endtask

    // stagger < 0: AW leads by -stagger cycles; > 0: W leads; 0: together.
    task automatic do_write(addr_t a, data_t d, strb_t s, int stagger, int bdelay);
        int unsigned e_aw, e_w, u;
        bit ok_aw, ok_w;
        fork
            begin
                if (stagger > 0) repeat (stagger) @(negedge aclk);
                aw_send(a, e_aw, ok_aw);
            end
            begin
                if (stagger < 0) repeat (-stagger) @(negedge aclk);
                w_send(d, s, e_w, ok_w);
            end
        join
        if (!ok_aw || !ok_w) begin fail_now("write_handshake"); return; end
        u = (e_aw == e_w) ? e_aw : ((e_aw > e_w) ? e_aw : e_w) + 1;
        model_write(a[4:2], d, s, u);
        b_q.push_back((a[4:2] >= 3'd5) ? RespSlverr : RespOkay);
        finish_b(bdelay);
    endtask

    task automatic do_read(addr_t a, int rdelay);
        rd_exp_t     ex;
        logic [63:0] v;
        bit          ok, seen;
        ok = 1'b0;
        axis_if.araddr  = a;
        axis_if.arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (axis_if.arready) begin
                v       = mval(cyc);
                ex.resp = RespOkay;
                case (a[4:2])
                    3'd0: begin ex.data = v[31:0]; m_shadow = v[63:32]; end
                    3'd1: ex.data = m_shadow;
                    3'd2: ex.data = m_cmp[31:0];
                    3'd3: ex.data = m_cmp[63:32];
                    3'd4: ex.data = {16'h0, m_div};
                    default: begin ex.data = '0; ex.resp = RespSlverr; end
                endcase
                r_q.push_back(ex);
                ok = 1'b1;
                @(negedge aclk);
                break;
            end
            @(negedge aclk);
        end
        axis_if.arvalid = 1'b0;
        if (!ok) begin fail_now("ar_handshake"); return; end
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (axis_if.rvalid) begin seen = 1'b1; break; end
            @(negedge aclk);
        end
        if (!seen) begin fail_now("rvalid_wait"); return; end
        repeat (rdelay) @(negedge aclk);
        axis_if.rready = 1'b1;
        @(negedge aclk);
        axis_if.rready = 1'b0;
    endtask

    task automatic apply_reset();
        aresetn         = 1'b0;
        axis_if.awvalid = 1'b0;
        axis_if.wvalid  = 1'b0;
        axis_if.arvalid = 1'b0;
        axis_if.bready  = 1'b0;
        axis_if.rready  = 1'b0;
        b_q.delete();
        r_q.delete();
        model_reset();
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic check_reset_state();
        #1;
        check("rst_awready", 64'(axis_if.awready), 64'd1);
        check("rst_wready", 64'(axis_if.wready), 64'd1);
        check("rst_arready", 64'(axis_if.arready), 64'd1);
        check("rst_bvalid", 64'(axis_if.bvalid), 64'd0);
        check("rst_rvalid", 64'(axis_if.rvalid), 64'd0);
        check("rst_rdata", 64'(axis_if.rdata), 64'd0);
        check("rst_bresp", 64'(axis_if.bresp), 64'(RespOkay));
        check("rst_rresp", 64'(axis_if.rresp), 64'(RespOkay));
        check("rst_irq", 64'(irq), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        logic [2:0] idx;
        addr_t      a;
        data_t      d;
        strb_t      s;
        axis_if.awaddr  = '0;
        axis_if.awvalid = 1'b0;
        axis_if.wdata   = '0;
        axis_if.wstrb   = '0;
        axis_if.wvalid  = 1'b0;
        axis_if.bready  = 1'b0;
        axis_if.araddr  = '0;
        axis_if.arvalid = 1'b0;
        axis_if.rready  = 1'b0;
        aresetn         = 1'b0;
        @(negedge aclk);
        apply_reset();
        check_reset_state();

        // Free-running count from reset, shadow reset value.
        repeat (10) @(negedge aclk);
        do_read(32'h0000_0000, 0);
        do_read(32'h0000_0004, 1);

        // Compare value written with AW leading W by three cycles; irq rises at mtime 0x20.
        do_write(32'h0000_000C, 32'h0, 4'hF, 0, 0);
        do_write(32'h0000_0008, 32'h0000_0020, 4'hF, -3, 0);
        repeat (20) @(negedge aclk);
        // Compare moved above mtime: irq falls.
        do_write(32'h0000_000C, 32'h1, 4'hF, 2, 1);
        repeat (4) @(negedge aclk);

        // Coherent 64-bit reads across the low-word carry.
        do_write(32'h0000_0010, 32'h1, 4'hF, 0, 0);
        do_write(32'h0000_0004, 32'h0, 4'hF, 0, 0);
        do_write(32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 0, 0);
        for (int i = 0; i < 3; i++) begin
            do_read(32'h0000_0000, i);
            do_read(32'h0000_0004, 0);
        end
        do_write(32'h0000_0000, 32'hFFFF_FFFA, 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) begin
            do_read(32'h0000_0000, 0);
            do_read(32'h0000_0004, 2);
        end

        // Prescaler DIV=3, then rewritten mid-count.
        do_write(32'h0000_0010, 32'h3, 4'hF, 0, 0);
        for (int i = 0; i < 3; i++) do_read(32'h0000_0000, i);
        repeat (2) @(negedge aclk);
        do_write(32'h0000_0010, 32'h3, 4'hF, 1, 0);
        do_read(32'h0000_0000, 0);
        do_read(32'h0000_0010, 0);

        // Byte strobes on the compare register.
        do_write(32'h0000_0008, 32'hFFFF_FFFF, 4'hF, 0, 0);
        do_write(32'h0000_0008, 32'hAABB_CCDD, 4'b0010, 0, 0);
        do_read(32'h0000_0008, 0);
        do_write(32'h0000_0008, 32'h1234_5678, 4'b0000, 0, 0);
        do_read(32'h0000_0008, 0);

        // Unmapped space and a stalled write response.
        do_read(32'h0000_0018, 0);
        do_write(32'h0000_0014, 32'hDEAD_BEEF, 4'hF, 0, 5);
        do_write(32'hFFFF_FF1C, 32'h1, 4'hF, -1, 0);

        // Randomised traffic.
        for (int i = 0; i < 200; i++) begin
            idx = 3'($urandom_range(0, 7));
            a   = {$urandom() & 32'hFFFF_FFE0} | {27'h0, idx, 2'b00} | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom();
                s = 4'($urandom_range(0, 15));
                if (idx == 3'd4) begin
                    d = 32'($urandom_range(0, 4));
                    s = 4'hF;
                end
                do_write(a, d, s, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
            end else begin
                do_read(a, int'($urandom_range(0, 3)));
            end
            repeat ($urandom_range(0, 3)) @(negedge aclk);
        end

        // Reset with only AW accepted: nothing may be answered or written.
        do_write(32'h0000_0008, 32'hFFFF_FFFF, 4'hF, 0, 0);
        axis_if.awaddr  = 32'h0000_0008;
        axis_if.awvalid = 1'b1;
        @(negedge aclk);
        axis_if.awvalid = 1'b0;
        apply_reset();
        check_reset_state();
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("bvalid_after_reset", 64'(axis_if.bvalid), 64'd0);
        end
        do_read(32'h0000_0008, 0);
        do_read(32'h0000_0000, 0);

        repeat (3) @(negedge aclk);
        checks++;
        if (b_q.size() != 0 || r_q.size() != 0) begin
            errors++;
            $display("FAIL pending_responses: got b=%0d r=%0d outstanding, expected 0",
                     b_q.size(), r_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
